// File: rtl/echo_ranger.sv
// Ultrasonic ranging controller: trigger pulse, echo synchroniser and
// prescaled echo-width measurement with timeout and holdoff.
module echo_ranger #(
    parameter int unsigned DIV           = 50,
    parameter int unsigned CNT_W         = 20,
    parameter int unsigned TRIG_TICKS    = 10,
    parameter int unsigned TIMEOUT_TICKS = 30000,
    parameter int unsigned HOLDOFF_TICKS = 60000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto_en,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic [CNT_W-1:0] width,
    output logic             valid,
    output logic             timeout
);

    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_MAX    = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic [2:0]       sync_q;

    logic             tick;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] tcnt_inc;

    // sync_q[1] is the synchronised echo, sync_q[2] its delayed copy
    assign rise     = sync_q[1] & ~sync_q[2];
    assign fall     = ~sync_q[1] & sync_q[2];
    assign tick     = (pre_q == PRE_MAX);
    assign tcnt_inc = tcnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            tcnt_q    <= '0;
            sync_q    <= '0;
            width_q   <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tcnt_q    <= tcnt_d;
            sync_q    <= {sync_q[1:0], echo};
            width_q   <= width_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start | auto_en) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (tick && tcnt_q == TRIG_LAST) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick && tcnt_q == TO_LAST) begin
                    width_d   = '1;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_HOLD;
                end else if (rise) begin
                    state_d = S_MEAS;
                end
            end
            S_MEAS: begin
                // a fall on the saturating tick still reports a clean width
                if (fall) begin
                    width_d   = tick ? tcnt_inc : tcnt_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_HOLD;
                end else if (tick && tcnt_inc == TO_MAX) begin
                    width_d   = TO_MAX;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tick && tcnt_q == HO_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            pre_d  = '0;
            tcnt_d = '0;
        end else begin
            pre_d  = tick ? '0 : pre_q + 1'b1;
            tcnt_d = (tick && state_q != S_IDLE) ? tcnt_inc : tcnt_q;
        end
    end

    assign trig    = (state_q == S_TRIG);
    assign busy    = (state_q != S_IDLE);
    assign width   = width_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_echo_ranger.sv
// Directed bench for echo_ranger: one DIV=1 instance for cycle-exact
// checks and one DIV=4 instance for prescaled width measurement.
module tb_echo_ranger;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       st1 = 1'b1, ae1 = 1'b0, ec1 = 1'b1;
    logic       trig1, busy1, valid1, to1;
    logic [7:0] width1;

    logic       st4 = 1'b0, ae4 = 1'b0, ec4 = 1'b0;
    logic       trig4, busy4, valid4, to4;
    logic [7:0] width4;

    int checks = 0;
    int errors = 0;
    int nrise1 = 0, nval1 = 0, nval4 = 0;
    logic trig1_prev = 1'b0;

    always #5 clk = ~clk;

    echo_ranger #(
        .DIV(1), .CNT_W(8), .TRIG_TICKS(3),
        .TIMEOUT_TICKS(20), .HOLDOFF_TICKS(8)
    ) u1 (
        .clk(clk), .reset(reset), .start(st1), .auto_en(ae1),
        .echo(ec1), .trig(trig1), .busy(busy1), .width(width1),
        .valid(valid1), .timeout(to1)
    );

    echo_ranger #(
        .DIV(4), .CNT_W(8), .TRIG_TICKS(2),
        .TIMEOUT_TICKS(20), .HOLDOFF_TICKS(4)
    ) u4 (
        .clk(clk), .reset(reset), .start(st4), .auto_en(ae4),
        .echo(ec4), .trig(trig4), .busy(busy4), .width(width4),
        .valid(valid4), .timeout(to4)
    );

    // event monitors sampled mid-cycle
    always @(negedge clk) begin
        if (trig1 === 1'b1 && trig1_prev === 1'b0) nrise1++;
        trig1_prev = trig1;
        if (valid1 === 1'b1) nval1++;
        if (valid4 === 1'b1) nval4++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int n;
    int r0, v0;
    int tcount;

    initial begin
        // reset held with start and echo asserted
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rst_outs1", {trig1, busy1, valid1, to1, width1}, 0);
            chk("rst_outs4", {trig4, busy4, valid4, to4, width4}, 0);
        end
        reset = 1'b1;
        ec1   = 1'b0;
        step(1);
        st1 = 1'b0;
        chk("start_trig", {31'd0, trig1}, 1);
        chk("start_busy", {31'd0, busy1}, 1);
        tcount = 1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (trig1) tcount++;
            if (!trig1) break;
        end
        chk("trig_len", tcount, 3);

        // no echo: timeout after 20 ticks in WAIT_RISE
        n = 0;
        while (!valid1 && n < 60) begin
            step(1);
            n++;
        end
        chk("noecho_lat", n, 20);
        chk("noecho_w", width1, 8'hFF);
        chk("noecho_to", {31'd0, to1}, 1);
        step(7);
        chk("noecho_hold", {31'd0, busy1}, 1);
        step(1);
        chk("noecho_idle", {31'd0, busy1}, 0);

        // stuck-high echo saturates at TIMEOUT_TICKS
        st1 = 1'b1;
        step(1);
        st1 = 1'b0;
        step(3);
        ec1 = 1'b1;
        n = 0;
        while (!valid1 && n < 60) begin
            step(1);
            n++;
        end
        chk("stuck_w", width1, 20);
        chk("stuck_to", {31'd0, to1}, 1);
        n = 0;
        while (busy1 && n < 40) begin
            step(1);
            n++;
        end
        chk("stuck_idle", {31'd0, busy1}, 0);
        ec1 = 1'b0;
        step(4);

        // normal 10-cycle echo, start pulses during MEASURE and HOLDOFF
        r0 = nrise1;
        v0 = nval1;
        st1 = 1'b1;
        step(1);
        st1 = 1'b0;
        step(3);
        ec1 = 1'b1;
        step(5);
        st1 = 1'b1;
        step(1);
        st1 = 1'b0;
        step(4);
        ec1 = 1'b0;
        step(3);
        chk("norm_valid", {31'd0, valid1}, 1);
        chk("norm_w", width1, 10);
        chk("norm_to", {31'd0, to1}, 0);
        step(1);
        chk("norm_strobe", {31'd0, valid1}, 0);
        chk("norm_wheld", width1, 10);
        st1 = 1'b1;
        step(1);
        st1 = 1'b0;
        step(6);
        chk("norm_idle", {31'd0, busy1}, 0);
        step(3);
        chk("drop_notrig", {30'd0, trig1, busy1}, 0);
        chk("drop_rises", nrise1 - r0, 1);
        chk("drop_valids", nval1 - v0, 1);

        // auto mode: back-to-back cycles, then auto_en dropped mid-MEASURE
        r0 = nrise1;
        v0 = nval1;
        ae1 = 1'b1;
        step(1);
        chk("auto_trig0", {31'd0, trig1}, 1);
        step(31);
        chk("auto_idle", {31'd0, busy1}, 0);
        step(1);
        chk("auto_retrig", {31'd0, trig1}, 1);
        step(3);
        ec1 = 1'b1;
        step(5);
        ae1 = 1'b0;
        step(2);
        ec1 = 1'b0;
        step(3);
        chk("auto_valid", {31'd0, valid1}, 1);
        chk("auto_w", width1, 7);
        chk("auto_to", {31'd0, to1}, 0);
        step(8);
        chk("auto_stop", {31'd0, busy1}, 0);
        step(5);
        chk("auto_stays", {30'd0, trig1, busy1}, 0);
        chk("auto_rises", nrise1 - r0, 2);
        chk("auto_valids", nval1 - v0, 2);

        // reset pulse mid-MEASURE
        v0 = nval1;
        st1 = 1'b1;
        step(1);
        st1 = 1'b0;
        step(3);
        ec1 = 1'b1;
        step(5);
        chk("mid_busy", {31'd0, busy1}, 1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk("mid_rst_outs", {trig1, busy1, valid1, to1, width1}, 0);
        step(10);
        ec1 = 1'b0;
        step(5);
        chk("mid_rst_idle", {30'd0, trig1, busy1}, 0);
        chk("mid_rst_noval", nval1 - v0, 0);
        chk("mid_rst_w", width1, 0);

        // DIV=4: 40-cycle echo gives about 10 ticks
        v0 = nval4;
        st4 = 1'b1;
        step(1);
        st4 = 1'b0;
        chk("d4_trig", {31'd0, trig4}, 1);
        step(7);
        chk("d4_trig_end", {31'd0, trig4}, 1);
        step(1);
        chk("d4_trig_low", {31'd0, trig4}, 0);
        ec4 = 1'b1;
        step(40);
        ec4 = 1'b0;
        n = 0;
        while (!valid4 && n < 40) begin
            step(1);
            n++;
        end
        chk("d4_valid", {31'd0, valid4}, 1);
        chk("d4_w_range", {31'd0, (width4 >= 8'd9 && width4 <= 8'd11)}, 1);
        chk("d4_to", {31'd0, to4}, 0);
        n = 0;
        while (busy4 && n < 60) begin
            step(1);
            n++;
        end
        chk("d4_idle", {31'd0, busy4}, 0);
        chk("d4_valids", nval4 - v0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
